gray_switch_decoder: RTL and testbench

Parametrised, registered successor to the combinational Gray-to-binary switch decoder. Synchronises an asynchronous WIDTH-bit Gray-coded switch/encoder input, debounces it, and converts each newly settled value to binary. Each settled value is presented through a valid/ready handshake. Flags overruns and Gray-code violations (more than one bit changing between settled values). Sits between the board switches and the downstream logic that consumes switch values.

---
 rtl/gray_switch_decoder.sv | 158 +++++++++++++++
 tb/tb_gray_switch_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/gray_switch_decoder.sv
// ---------------------------------------------------------------------------
// gray_switch_decoder
//
// Registered Gray-to-binary decoder for board switches / rotary encoders.
// The asynchronous Gray input is synchronised, debounced, and every newly
// settled value is converted to binary and offered through a valid/ready
// handshake. Multi-bit jumps between settled values and values overwritten
// before delivery are flagged.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   gray_in    raw Gray-coded input, asynchronous to clk
//   bin_out    binary value of the last accepted Gray value
//   bin_valid  bin_out holds an undelivered value
//   bin_ready  consumer accepts bin_out when high together with bin_valid
//   stable     synchronised input matches the accepted value, nothing settling
//   gray_err   one-cycle pulse: accepted value jumped by more than one bit
//   overrun    sticky: an undelivered value was replaced (cleared by rst only)
// ---------------------------------------------------------------------------
module gray_switch_decoder #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  input  logic             bin_ready,
  output logic             stable,
  output logic             gray_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCEPT = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] candidate_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] accepted_q;
  logic             first_q;
  state_t           state_q;
  state_t           state_d;
  logic             accept;

  // Synchroniser stage boundary: gray_in -> sync
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_p[i] <= '0;
      end
    end else begin
      sync_p[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_p[i] <= sync_p[i-1];
      end
    end
  end

  assign sync = sync_p[SYNC_STAGES-1];

  // Debounce stage boundary: any change restarts the count on the new candidate
  always_ff @(posedge clk) begin
    if (rst) begin
      candidate_q <= '0;
      cnt_q       <= '0;
    end else if (sync != candidate_q) begin
      candidate_q <= sync;
      cnt_q       <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SETTLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A settle that lands back on the old value is silent, except right after
  // reset where the first settled value is always delivered (even if 0).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STABLE: begin
        if (sync != accepted_q) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_MAX) begin
          if ((candidate_q != accepted_q) || first_q) state_d = ST_ACCEPT;
          else                                        state_d = ST_STABLE;
        end
      end
      ST_ACCEPT: state_d = ST_STABLE;
      default:   state_d = ST_SETTLE;
    endcase
  end

  assign accept = (state_q == ST_ACCEPT);
  assign stable = (state_q == ST_STABLE);

  // Output stage boundary: conversion, handshake and error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      accepted_q <= '0;
      first_q    <= 1'b1;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      gray_err   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      gray_err <= 1'b0;
      if (accept) begin
        accepted_q <= candidate_q;
        first_q    <= 1'b0;
        bin_out    <= gray_to_bin(candidate_q);
        bin_valid  <= 1'b1;
        gray_err   <= (popcount(candidate_q ^ accepted_q) > 1) && !first_q;
        // Loading alongside a completed handshake is not an overrun.
        if (bin_valid && !bin_ready) overrun <= 1'b1;
      end else if (bin_valid && bin_ready) begin
        bin_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_switch_decoder.sv
module tb_gray_switch_decoder;

  localparam int WIDTH           = 4;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             bin_ready;
  logic             stable;
  logic             gray_err;
  logic             overrun;

  int tests;
  int fails;
  int vld_seen;
  int err_seen;
  logic [WIDTH-1:0] err_bin;
  int k;

  gray_switch_decoder #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .gray_in  (gray_in),
    .bin_out  (bin_out),
    .bin_valid(bin_valid),
    .bin_ready(bin_ready),
    .stable   (stable),
    .gray_err (gray_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling on the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bin_valid === 1'b1) vld_seen++;
      if (gray_err === 1'b1) begin
        err_seen++;
        err_bin = bin_out;
      end
    end
  endtask

  // Count rising edges until bin_valid is seen, bounded at 20.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (bin_valid !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    vld_seen = 0;
    err_seen = 0;
    err_bin  = '0;
    rst       = 1'b1;
    gray_in   = 4'b0000;
    bin_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_bin_out",   32'(bin_out),   32'h0);
    check("rst_bin_valid", 32'(bin_valid), 32'h0);
    check("rst_stable",    32'(stable),    32'h0);
    check("rst_gray_err",  32'(gray_err),  32'h0);
    check("rst_overrun",   32'(overrun),   32'h0);

    // 1: first value after reset (0000) is delivered once
    rst = 1'b0;
    wait_valid(k);
    check("s1_latency_le8", 32'(k >= 1 && k <= 8), 32'h1);
    check("s1_bin_out",     32'(bin_out),  32'h0);
    check("s1_gray_err",    32'(gray_err), 32'h0);
    vld_seen = 0;
    tick(12);
    check("s1_single_pulse", 32'(vld_seen), 32'h0);

    // 2: 0000 -> 0110, valid exactly 8 edges after the first sampling edge
    gray_in = 4'b0110;
    wait_valid(k);
    check("s2_latency", 32'(k), 32'd9);
    check("s2_bin_out", 32'(bin_out), 32'h4);
    tick(3);
    check("s2_stable",    32'(stable),    32'h1);
    check("s2_valid_off", 32'(bin_valid), 32'h0);

    // 3: bouncing 0110 <-> 0111 then back to 0110: no new value
    vld_seen = 0;
    for (int i = 0; i < 5; i++) begin
      gray_in = 4'b0111;
      tick(2);
      gray_in = 4'b0110;
      tick(2);
      if (i == 2) check("s3_stable_bounce", 32'(stable), 32'h0);
    end
    tick(12);
    check("s3_no_valid",     32'(vld_seen), 32'h0);
    check("s3_stable_after", 32'(stable),   32'h1);

    // 4: overrun with bin_ready low
    bin_ready = 1'b0;
    gray_in   = 4'b1100;
    tick(12);
    check("s4a_valid",   32'(bin_valid), 32'h1);
    check("s4a_bin_out", 32'(bin_out),   32'h8);
    check("s4a_overrun", 32'(overrun),   32'h0);
    gray_in = 4'b1101;
    tick(12);
    check("s4b_valid",   32'(bin_valid), 32'h1);
    check("s4b_bin_out", 32'(bin_out),   32'h9);
    check("s4b_overrun", 32'(overrun),   32'h1);
    bin_ready = 1'b1;
    tick(1);
    bin_ready = 1'b0;
    check("s4c_valid",   32'(bin_valid), 32'h0);
    check("s4c_overrun", 32'(overrun),   32'h1);

    // 5: accepted 0000, then 0011 -> two-bit jump flagged for one cycle
    bin_ready = 1'b1;
    gray_in   = 4'b0000;
    tick(12);
    vld_seen = 0;
    err_seen = 0;
    err_bin  = '0;
    gray_in  = 4'b0011;
    tick(14);
    check("s5_bin_out",   32'(bin_out),  32'h2);
    check("s5_err_count", 32'(err_seen), 32'h1);
    check("s5_err_value", 32'(err_bin),  32'h2);
    check("s5_vld_count", 32'(vld_seen), 32'h1);

    // 6: reset mid-settle with a pending value
    bin_ready = 1'b0;
    gray_in   = 4'b0001;
    tick(12);
    check("s6_pending", 32'(bin_valid), 32'h1);
    gray_in = 4'b0101;
    tick(5);
    check("s6_settling", 32'(stable), 32'h0);
    rst = 1'b1;
    tick(1);
    check("s6_rst_bin_out",   32'(bin_out),   32'h0);
    check("s6_rst_bin_valid", 32'(bin_valid), 32'h0);
    check("s6_rst_stable",    32'(stable),    32'h0);
    check("s6_rst_gray_err",  32'(gray_err),  32'h0);
    check("s6_rst_overrun",   32'(overrun),   32'h0);
    rst       = 1'b0;
    bin_ready = 1'b1;
    wait_valid(k);
    check("s6_latency",  32'(k),        32'd9);
    check("s6_bin_out",  32'(bin_out),  32'h6);
    check("s6_gray_err", 32'(gray_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
